// File: rtl/rom_playback_sequencer.sv
// Paces audio ROM playback at one word per DIVIDE_BY clocks; capture lands ROM_LATENCY+1 clocks after the tick.
// A captured sample waits in sample_out until write_ready; an unconsumed sample is overwritten and counted.
module rom_playback_sequencer #(
    parameter int DIVIDE_BY   = 1250,
    parameter int ROM_SIZE    = 52612,
    parameter int ADDR_W      = 16,
    parameter int ROM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_q,
    input  logic              write_ready,
    output logic              write,
    output logic [23:0]       sample_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        overrun_cnt
);

    localparam int                CNT_W     = (DIVIDE_BY > 1) ? $clog2(DIVIDE_BY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIVIDE_BY - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROM_SIZE - 1);
    localparam logic [1:0]        LAT_LAST  = 2'(ROM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, FETCH, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pending_q, pending_d;
    logic [23:0]       sample_q, sample_d;
    logic [7:0]        overrun_q, overrun_d;
    logic              tick;
    logic              capture;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            lat_q     <= '0;
            addr_q    <= '0;
            pending_q <= 1'b0;
            sample_q  <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
        end
    end

    assign tick = (count_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                lat_d   = '0;
                addr_d  = '0;
                if (play) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                count_d = tick ? '0 : count_q + 1'b1;
                if (!play) begin
                    state_d = IDLE;
                    addr_d  = '0;
                    count_d = '0;
                end else if (tick) begin
                    state_d = FETCH;
                    lat_d   = '0;
                end
            end
            FETCH: begin
                // Counter keeps running through the fetch so the sample period stays exact.
                count_d = tick ? '0 : count_q + 1'b1;
                lat_d   = lat_q + 1'b1;
                if (lat_q == LAT_LAST) begin
                    capture = 1'b1;
                    lat_d   = '0;
                    if (!play) begin
                        state_d = IDLE;
                        addr_d  = '0;
                        count_d = '0;
                    end else if (addr_q != ADDR_LAST) begin
                        state_d = WAIT_TICK;
                        addr_d  = addr_q + 1'b1;
                    end else if (loop) begin
                        state_d = WAIT_TICK;
                        addr_d  = '0;
                    end else begin
                        state_d = DONE;
                        count_d = '0;
                    end
                end
            end
            DONE: begin
                count_d = '0;
                if (!play) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write     = pending_q & write_ready;
        pending_d = capture | (pending_q & ~write);
        sample_d  = capture ? {rom_q, 8'h00} : sample_q;
        overrun_d = overrun_q;
        // A capture coinciding with a write is a clean hand-over, not an overrun.
        if (capture && pending_q && !write && overrun_q != 8'hFF)
            overrun_d = overrun_q + 8'd1;
    end

    assign rom_addr    = addr_q;
    assign sample_out  = sample_q;
    assign busy        = (state_q == WAIT_TICK) || (state_q == FETCH);
    assign done        = (state_q == DONE);
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_rom_playback_sequencer.sv
// Scoreboard bench: directed scenarios push expected samples; a monitor pops one per write.
module tb_rom_playback_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic        loop = 1'b0;
    logic [15:0] rom_addr;
    logic [15:0] rom_q = '0;
    logic [15:0] rom_r1 = '0;
    logic        write_ready = 1'b1;
    logic        write;
    logic [23:0] sample_out;
    logic        busy;
    logic        done;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    rom_playback_sequencer #(
        .DIVIDE_BY(8), .ROM_SIZE(4), .ADDR_W(16), .ROM_LATENCY(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .loop(loop),
        .rom_addr(rom_addr), .rom_q(rom_q), .write_ready(write_ready),
        .write(write), .sample_out(sample_out), .busy(busy), .done(done),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Two-deep registered ROM returning addr*0x1111
    always @(posedge clk) begin
        rom_r1 <= 16'(rom_addr * 16'h1111);
        rom_q  <= rom_r1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        play = 1'b0;
        loop = 1'b0;
        write_ready = 1'b1;
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && write) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write sample=%h time=%0t", sample_out, $time);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if (sample_out !== e) begin
                        failures++;
                        $display("FAIL write_sample actual=%h expected=%h time=%0t", sample_out, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state and idle with play low
        do_reset();
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_outs", {write, busy, done, 21'(sample_out)}, 0);
        chk("rst_ovr", 32'(overrun_cnt), 0);
        step(20);
        chk("idle_outs", {write, busy, done, rom_addr, 8'(overrun_cnt)}, 0);

        // Single pass, loop=0
        do_reset();
        exp_q.push_back(24'h000000); exp_q.push_back(24'h111100);
        exp_q.push_back(24'h222200); exp_q.push_back(24'h333300);
        play = 1'b1;
        step(10);
        chk("p1_c10_write", 32'(write), 0);
        step(1);
        chk("p1_c11_write", 32'(write), 1);
        chk("p1_c11_addr", 32'(rom_addr), 1);
        step(23);
        chk("p1_c34_done", {done, busy}, 2'b01);
        step(1);
        chk("p1_c35_done", {done, busy}, 2'b10);
        chk("p1_c35_sample", 32'(sample_out), 32'h333300);
        chk("p1_c35_addr", 32'(rom_addr), 3);
        step(1);
        chk("p1_ovr", 32'(overrun_cnt), 0);
        chk("p1_drained", exp_q.size(), 0);
        play = 1'b0;
        step(1);
        chk("p1_idle", {done, rom_addr}, 0);

        // Looping, six ticks
        do_reset();
        exp_q.push_back(24'h000000); exp_q.push_back(24'h111100);
        exp_q.push_back(24'h222200); exp_q.push_back(24'h333300);
        exp_q.push_back(24'h000000); exp_q.push_back(24'h111100);
        loop = 1'b1;
        play = 1'b1;
        step(34);
        chk("lp_c34_addr", 32'(rom_addr), 3);
        step(1);
        chk("lp_c35_addr", 32'(rom_addr), 0);
        chk("lp_c35_done", 32'(done), 0);
        step(16);
        chk("lp_c51_addr", 32'(rom_addr), 2);
        play = 1'b0;
        step(2);
        chk("lp_drained", exp_q.size(), 0);
        chk("lp_done", {done, busy}, 0);

        // Backpressure: three captures unconsumed
        do_reset();
        exp_q.push_back(24'h222200);
        write_ready = 1'b0;
        play = 1'b1;
        step(19);
        chk("bp_c19_ovr", 32'(overrun_cnt), 1);
        step(8);
        chk("bp_c27_ovr", 32'(overrun_cnt), 2);
        chk("bp_c27_sample", 32'(sample_out), 32'h222200);
        write_ready = 1'b1;
        play = 1'b0;
        step(2);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_ovr_final", 32'(overrun_cnt), 2);
        step(20);
        chk("bp_busy", 32'(busy), 0);

        // Stop while fetching address 1
        do_reset();
        exp_q.push_back(24'h000000); exp_q.push_back(24'h111100);
        play = 1'b1;
        step(17);
        play = 1'b0;
        step(1);
        chk("st_c18_busy", 32'(busy), 1);
        step(1);
        chk("st_c19_sample", 32'(sample_out), 32'h111100);
        chk("st_c19_state", {busy, rom_addr}, 0);
        step(2);
        chk("st_drained", exp_q.size(), 0);

        // Asynchronous reset mid-fetch, play held high
        do_reset();
        exp_q.push_back(24'h000000);
        play = 1'b1;
        step(18);
        reset_n = 1'b0;
        #1;
        chk("ar_addr", 32'(rom_addr), 0);
        chk("ar_outs", {write, busy, done, 8'(overrun_cnt)}, 0);
        chk("ar_drained", exp_q.size(), 0);
        step(1);
        chk("ar_sample", 32'(sample_out), 0);
        step(1);
        reset_n = 1'b1;
        exp_q.push_back(24'h000000); exp_q.push_back(24'h111100);
        step(10);
        chk("ar_c30_addr", 32'(rom_addr), 0);
        step(1);
        chk("ar_c31_addr", 32'(rom_addr), 1);
        step(9);
        play = 1'b0;
        step(2);
        chk("ar_restart_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
